mem_access_controller: RTL

Sequences all traffic into the byte-wide data memory array. After reset it runs a boot phase that streams program or data bytes into consecutive addresses. It then serves CPU word and byte load/store requests by splitting each into byte beats on the memory port. The byte order is big-endian, with the byte at the base address holding bits 31:24.

---
 rtl/mem_access_controller.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_controller.sv
// mem_access_controller: single owner of the byte-wide data memory port.
// After reset it runs a boot phase that streams bytes into consecutive
// addresses. It then serves CPU word/byte loads and stores as big-endian
// byte beats (the byte at the base address holds bits 31:24).
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   load_valid/byte/done       boot byte stream and end-of-stream marker
//   boot_active, load_count    boot phase flag, next boot write address
//   cpu_req/we/size/addr/wdata CPU request (held until cpu_done)
//   cpu_rdata/done/err/busy    CPU response; err flags a misaligned word access
//   mem_addr/wdata/we/re       memory strobes; mem_rdata is valid one cycle after mem_re
module mem_access_controller #(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  input  logic              load_done,
  output logic              boot_active,
  output logic [ADDR_W-1:0] load_count,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic              cpu_size,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              cpu_busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata
);

  typedef enum logic [2:0] {
    S_BOOT, S_IDLE, S_WRITE, S_READ, S_WAIT_LAST, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] load_count_q, load_count_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        beat_q, beat_d;
  logic [23:0]       rbuf_q, rbuf_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic              cpu_done_q, cpu_done_d;
  logic              cpu_err_q, cpu_err_d;
  logic              boot_active_q, boot_active_d;
  logic              cpu_busy_q, cpu_busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              mem_we_q, mem_we_d;
  logic              mem_re_q, mem_re_d;

  logic              misaligned_c;
  logic              last_beat_c;
  logic [1:0]        next_beat_c;
  logic              unused_addr_bits_c;

  // Upper address bits are dropped so accesses wrap within the array.
  assign unused_addr_bits_c = ^cpu_addr[31:ADDR_W];

  assign misaligned_c = cpu_size & (cpu_addr[1:0] != 2'b00);
  // beat_q indexes the beat currently on the memory port.
  assign last_beat_c  = ~size_q | (beat_q == 2'd3);
  assign next_beat_c  = beat_q + 2'd1;

  // Big-endian byte lane selection: beat 0 carries bits 31:24.
  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    case (idx)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_BOOT;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_BOOT:      if (load_done) state_d = S_IDLE;
      S_IDLE:      if (cpu_req) state_d = misaligned_c ? S_DONE : (cpu_we ? S_WRITE : S_READ);
      S_WRITE:     if (last_beat_c) state_d = S_DONE;
      S_READ:      if (last_beat_c) state_d = S_WAIT_LAST;
      S_WAIT_LAST: state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_BOOT;
    endcase
  end

  // Output and datapath next values; every output is registered below.
  always_comb begin
    load_count_d  = load_count_q;
    base_d        = base_q;
    size_d        = size_q;
    wdata_d       = wdata_q;
    beat_d        = beat_q;
    rbuf_d        = rbuf_q;
    cpu_rdata_d   = cpu_rdata_q;
    cpu_done_d    = 1'b0;
    cpu_err_d     = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = 1'b0;
    mem_re_d      = 1'b0;
    boot_active_d = (state_d == S_BOOT);
    cpu_busy_d    = (state_d != S_IDLE);
    unique case (state_q)
      S_BOOT: begin
        if (load_valid) begin
          mem_we_d     = 1'b1;
          mem_addr_d   = load_count_q;
          mem_wdata_d  = load_byte;
          load_count_d = load_count_q + ADDR_W'(1);
        end
      end
      S_IDLE: begin
        if (cpu_req) begin
          base_d  = cpu_addr[ADDR_W-1:0];
          size_d  = cpu_size;
          wdata_d = cpu_wdata;
          beat_d  = 2'd0;
          if (misaligned_c) begin
            cpu_done_d = 1'b1;
            cpu_err_d  = 1'b1;
          end else begin
            mem_addr_d = cpu_addr[ADDR_W-1:0];
            if (cpu_we) begin
              mem_we_d    = 1'b1;
              mem_wdata_d = cpu_size ? cpu_wdata[31:24] : cpu_wdata[7:0];
            end else begin
              mem_re_d = 1'b1;
            end
          end
        end
      end
      S_WRITE: begin
        if (last_beat_c) begin
          cpu_done_d = 1'b1;
        end else begin
          mem_we_d    = 1'b1;
          mem_addr_d  = base_q + ADDR_W'(next_beat_c);
          mem_wdata_d = word_byte(wdata_q, next_beat_c);
          beat_d      = next_beat_c;
        end
      end
      S_READ: begin
        // Read data lags the strobe by one cycle, so capture the previous beat.
        if (beat_q != 2'd0) rbuf_d = {rbuf_q[15:0], mem_rdata};
        if (!last_beat_c) begin
          mem_re_d   = 1'b1;
          mem_addr_d = base_q + ADDR_W'(next_beat_c);
          beat_d     = next_beat_c;
        end
      end
      S_WAIT_LAST: begin
        cpu_done_d  = 1'b1;
        cpu_rdata_d = size_q ? {rbuf_q, mem_rdata} : {24'd0, mem_rdata};
      end
      default: ;
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_count_q  <= '0;
      base_q        <= '0;
      size_q        <= 1'b0;
      wdata_q       <= '0;
      beat_q        <= '0;
      rbuf_q        <= '0;
      cpu_rdata_q   <= '0;
      cpu_done_q    <= 1'b0;
      cpu_err_q     <= 1'b0;
      boot_active_q <= 1'b1;
      cpu_busy_q    <= 1'b1;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_we_q      <= 1'b0;
      mem_re_q      <= 1'b0;
    end else begin
      load_count_q  <= load_count_d;
      base_q        <= base_d;
      size_q        <= size_d;
      wdata_q       <= wdata_d;
      beat_q        <= beat_d;
      rbuf_q        <= rbuf_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cpu_done_q    <= cpu_done_d;
      cpu_err_q     <= cpu_err_d;
      boot_active_q <= boot_active_d;
      cpu_busy_q    <= cpu_busy_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      mem_re_q      <= mem_re_d;
    end
  end

  assign boot_active = boot_active_q;
  assign load_count  = load_count_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign cpu_done    = cpu_done_q;
  assign cpu_err     = cpu_err_q;
  assign cpu_busy    = cpu_busy_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;
  assign mem_re      = mem_re_q;

endmodule
